// File: rtl/logic_unit_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : logic_unit_pipe                                              |
// | Description : Two-stage pipelined bitwise logic unit. Eight gate functions |
// |               over WIDTH-bit operands, valid/ready on both sides, chain    |
// |               mode (operand a taken from the last accepted result), and    |
// |               zero/parity flags registered with the result.                |
// |               Optional macro LOGIC_UNIT_POPCNT_EN adds a registered        |
// |               population-count output (out_popcnt).                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module logic_unit_pipe #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic             in_chain,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
   output logic             out_parity
`ifdef LOGIC_UNIT_POPCNT_EN
   ,
   output logic [$clog2(WIDTH+1)-1:0] out_popcnt
`endif
);

   localparam logic [2:0] c_OP_NOTA = 3'd0;
   localparam logic [2:0] c_OP_NOTB = 3'd1;
   localparam logic [2:0] c_OP_AND  = 3'd2;
   localparam logic [2:0] c_OP_OR   = 3'd3;
   localparam logic [2:0] c_OP_NAND = 3'd4;
   localparam logic [2:0] c_OP_NOR  = 3'd5;
   localparam logic [2:0] c_OP_XOR  = 3'd6;
   localparam logic [2:0] c_OP_XNOR = 3'd7;

   logic             r_s1_valid;
   logic [WIDTH-1:0] r_s1_result;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_result;
   logic             r_out_zero;
   logic             r_out_parity;
   logic [WIDTH-1:0] r_acc;

   logic             w_in_ready;
   logic             w_accept;
   logic             w_advance;
   logic [WIDTH-1:0] w_opa;
   logic [WIDTH-1:0] w_res;

   // Handshake: s1 may move forward whenever the out stage is empty or being
   // drained; input is accepted whenever s1 is empty or is itself moving.
   assign w_in_ready = !r_s1_valid || !r_out_valid || out_ready;
   assign w_accept   = in_valid && w_in_ready;
   assign w_advance  = r_s1_valid && (!r_out_valid || out_ready);
   assign w_opa      = in_chain ? r_acc : in_a;

   // Gate function evaluated at accept; chained ops see the acc written by the
   // immediately preceding accept, so back-to-back chaining needs no stall.
   always_comb begin
      w_res = '0;
      case (in_op)
         c_OP_NOTA: w_res = ~w_opa;
         c_OP_NOTB: w_res = ~in_b;
         c_OP_AND:  w_res = w_opa & in_b;
         c_OP_OR:   w_res = w_opa | in_b;
         c_OP_NAND: w_res = ~(w_opa & in_b);
         c_OP_NOR:  w_res = ~(w_opa | in_b);
         c_OP_XOR:  w_res = w_opa ^ in_b;
         c_OP_XNOR: w_res = ~(w_opa ^ in_b);
         default:   w_res = '0;
      endcase
   end

`ifdef LOGIC_UNIT_POPCNT_EN
   localparam int c_PCNT_W = $clog2(WIDTH+1);

   logic [c_PCNT_W-1:0] w_popcnt;
   logic [c_PCNT_W-1:0] r_out_popcnt;

   // Population count of the s1 result, captured alongside the other flags.
   always_comb begin
      w_popcnt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_popcnt = w_popcnt + c_PCNT_W'(r_s1_result[i]);
      end
   end

   // Popcount register follows the out stage load enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_popcnt <= '0;
      end else if (w_advance) begin
         r_out_popcnt <= w_popcnt;
      end
   end

   assign out_popcnt = r_out_popcnt;
`endif

   // Pipeline registers: acc, stage 1 and the out stage with its flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc        <= '0;
         r_s1_valid   <= 1'b0;
         r_s1_result  <= '0;
         r_out_valid  <= 1'b0;
         r_out_result <= '0;
         r_out_zero   <= 1'b1;
         r_out_parity <= 1'b0;
      end else begin
         if (w_accept) begin
            r_acc       <= w_res;
            r_s1_result <= w_res;
            r_s1_valid  <= 1'b1;
         end else if (w_advance) begin
            r_s1_valid  <= 1'b0;
         end

         if (w_advance) begin
            r_out_valid  <= 1'b1;
            r_out_result <= r_s1_result;
            r_out_zero   <= (r_s1_result == '0);
            r_out_parity <= ^r_s1_result;
         end else if (out_ready) begin
            r_out_valid  <= 1'b0;
         end
      end
   end

   assign in_ready   = w_in_ready;
   assign out_valid  = r_out_valid;
   assign out_result = r_out_result;
   assign out_zero   = r_out_zero;
   assign out_parity = r_out_parity;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_logic_unit_pipe                                           |
// | Description : Scoreboard bench for logic_unit_pipe (WIDTH=8). Expected     |
// |               results are queued on accept and popped on output handshake. |
// |               The popcount scenario is built with LOGIC_UNIT_POPCNT_EN.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_logic_unit_pipe;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_op;
   logic             in_chain;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic             out_zero;
   logic             out_parity;
`ifdef LOGIC_UNIT_POPCNT_EN
   logic [$clog2(WIDTH+1)-1:0] out_popcnt;
`endif

   logic_unit_pipe #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_chain   (in_chain),
      .in_a       (in_a),
      .in_b       (in_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_zero   (out_zero),
      .out_parity (out_parity)
`ifdef LOGIC_UNIT_POPCNT_EN
      ,
      .out_popcnt (out_popcnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [WIDTH-1:0] res;
      logic             zero;
      logic             parity;
   } exp_t;

   exp_t             sbq[$];
   int               vectors     = 0;
   int               miscompares = 0;
   int               cyc         = 0;
   logic [WIDTH-1:0] m_acc       = '0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [WIDTH-1:0] gate(input logic [2:0] op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
      case (op)
         3'd0:    return ~a;
         3'd1:    return ~b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return ~(a & b);
         3'd5:    return ~(a | b);
         3'd6:    return a ^ b;
         default: return ~(a ^ b);
      endcase
   endfunction

   function automatic exp_t mk(input logic [WIDTH-1:0] r);
      exp_t e;
      e.res    = r;
      e.zero   = (r == '0);
      e.parity = ^r;
      return e;
   endfunction

   // Reference model for one accepted transaction: queue result, update acc.
   task automatic model_accept();
      logic [WIDTH-1:0] a_eff;
      logic [WIDTH-1:0] r;
      a_eff = in_chain ? m_acc : in_a;
      r     = gate(in_op, a_eff, in_b);
      m_acc = r;
      sbq.push_back(mk(r));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_chain = 1'b0;
      in_op = 3'd0; in_a = '0; in_b = '0;
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      vectors += 5;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
      if (out_result !== 8'h00) begin miscompares++; $display("FAIL reset_out_result: got %h, required 00", out_result); end
      if (out_zero !== 1'b1) begin miscompares++; $display("FAIL reset_out_zero: got %b, required 1", out_zero); end
      if (out_parity !== 1'b0) begin miscompares++; $display("FAIL reset_out_parity: got %b, required 0", out_parity); end
      tick();
   endtask

   task automatic test_all_ops();
      logic [WIDTH-1:0] tbl [8];
      exp_t e;
      int   idx = 0;
      tbl = '{8'h3A, 8'hC5, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00};
      out_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         in_valid = (idx < 8); in_op = 3'(idx); in_a = 8'hC5; in_b = 8'h3A; in_chain = 1'b0;
         @(negedge clk);
         if (in_valid && in_ready) begin
            sbq.push_back(mk(tbl[idx])); m_acc = tbl[idx]; idx++;
         end
         if (out_valid && out_ready) begin
            vectors++;
            if (sbq.size() == 0) begin miscompares++; $display("FAIL ops_extra: got %h, required no output", out_result); end
            else begin
               e = sbq.pop_front();
               if ({out_result, out_zero, out_parity} !== e) begin
                  miscompares++;
                  $display("FAIL ops_result: got %h z%b p%b, required %h z%b p%b", out_result, out_zero, out_parity, e.res, e.zero, e.parity);
               end
            end
         end
         tick();
      end
      vectors++;
      if (sbq.size() != 0 || idx != 8) begin miscompares++; $display("FAIL ops_drain: got %0d pending/%0d sent, required 0/8", sbq.size(), idx); end
   endtask

   task automatic test_back_to_back();
      logic [2:0]       ops [16];
      logic [WIDTH-1:0] as  [16];
      logic [WIDTH-1:0] bs  [16];
      logic             chs [16];
      exp_t e;
      int idx = 0, npop = 0, first_acc = -1, first_pop = -1, last_pop = -1;
      for (int i = 0; i < 16; i++) begin
         ops[i] = 3'($urandom_range(0, 7)); as[i] = 8'($urandom); bs[i] = 8'($urandom);
         chs[i] = 1'($urandom_range(0, 1));
      end
      out_ready = 1'b1;
      for (int c = 0; c < 40 && (idx < 16 || npop < 16); c++) begin
         in_valid = (idx < 16);
         if (idx < 16) begin in_op = ops[idx]; in_a = as[idx]; in_b = bs[idx]; in_chain = chs[idx]; end
         @(negedge clk);
         if (in_valid && in_ready) begin
            if (first_acc < 0) first_acc = cyc;
            model_accept(); idx++;
         end
         if (out_valid && out_ready) begin
            vectors++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc; npop++;
            if (sbq.size() == 0) begin miscompares++; $display("FAIL b2b_extra: got %h, required no output", out_result); end
            else begin
               e = sbq.pop_front();
               if ({out_result, out_zero, out_parity} !== e) begin
                  miscompares++;
                  $display("FAIL b2b_result: got %h z%b p%b, required %h z%b p%b", out_result, out_zero, out_parity, e.res, e.zero, e.parity);
               end
            end
         end
         tick();
      end
      in_valid = 1'b0; in_chain = 1'b0;
      vectors += 3;
      if (npop != 16 || idx != 16) begin miscompares++; $display("FAIL b2b_count: got %0d out/%0d in, required 16/16", npop, idx); end
      if (first_pop - first_acc != 2) begin miscompares++; $display("FAIL b2b_latency: got %0d cycles, required 2", first_pop - first_acc); end
      if (last_pop - first_pop != 15) begin miscompares++; $display("FAIL b2b_throughput: got span %0d, required 15", last_pop - first_pop); end
   endtask

   task automatic test_backpressure();
      exp_t e;
      logic [WIDTH-1:0] hold = '0;
      int acc_cnt = 0, npop = 0;
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1; in_op = 3'($urandom_range(0, 7)); in_a = 8'($urandom); in_b = 8'($urandom);
         in_chain = 1'b0;
         @(negedge clk);
         if (c >= 2) begin
            vectors++;
            if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready: got %b at stall cycle %0d, required 0", in_ready, c); end
         end
         if (c == 2) hold = out_result;
         if (c == 4) begin
            vectors++;
            if (out_result !== hold || out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_stable: got %h v%b, required %h v1", out_result, out_valid, hold); end
         end
         if (in_valid && in_ready) begin model_accept(); acc_cnt++; end
         tick();
      end
      vectors++;
      if (acc_cnt != 2) begin miscompares++; $display("FAIL bp_accepts: got %0d, required 2", acc_cnt); end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            vectors++; npop++;
            if (sbq.size() == 0) begin miscompares++; $display("FAIL bp_dup: got %h, required no output", out_result); end
            else begin
               e = sbq.pop_front();
               if ({out_result, out_zero, out_parity} !== e) begin
                  miscompares++;
                  $display("FAIL bp_result: got %h z%b p%b, required %h z%b p%b", out_result, out_zero, out_parity, e.res, e.zero, e.parity);
               end
            end
         end
         tick();
      end
      vectors++;
      if (npop != 2 || sbq.size() != 0) begin miscompares++; $display("FAIL bp_loss: got %0d out/%0d pending, required 2/0", npop, sbq.size()); end
   endtask

   task automatic test_random_stall();
      exp_t e;
      for (int c = 0; c < 60; c++) begin
         in_valid = (c < 50) && ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0) || (c >= 50);
         in_op = 3'($urandom_range(0, 7)); in_a = 8'($urandom); in_b = 8'($urandom);
         in_chain = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (in_valid && in_ready) model_accept();
         if (out_valid && out_ready) begin
            vectors++;
            if (sbq.size() == 0) begin miscompares++; $display("FAIL rnd_extra: got %h, required no output", out_result); end
            else begin
               e = sbq.pop_front();
               if ({out_result, out_zero, out_parity} !== e) begin
                  miscompares++;
                  $display("FAIL rnd_result: got %h z%b p%b, required %h z%b p%b", out_result, out_zero, out_parity, e.res, e.zero, e.parity);
               end
            end
         end
         tick();
      end
      in_valid = 1'b0; in_chain = 1'b0;
      vectors++;
      if (sbq.size() != 0) begin miscompares++; $display("FAIL rnd_drain: got %0d pending, required 0", sbq.size()); end
   endtask

   task automatic test_chain();
      logic [2:0]       ops [3];
      logic [WIDTH-1:0] as  [3];
      logic [WIDTH-1:0] bs  [3];
      logic             chs [3];
      logic [WIDTH-1:0] tbl [3];
      exp_t e;
      int idx = 0;
      ops = '{3'd2, 3'd6, 3'd0}; as = '{8'hFF, 8'h55, 8'hAA}; bs = '{8'h0F, 8'h03, 8'h00};
      chs = '{1'b0, 1'b1, 1'b1}; tbl = '{8'h0F, 8'h0C, 8'hF3};
      out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         in_valid = (idx < 3);
         if (idx < 3) begin in_op = ops[idx]; in_a = as[idx]; in_b = bs[idx]; in_chain = chs[idx]; end
         @(negedge clk);
         if (in_valid && in_ready) begin
            sbq.push_back(mk(tbl[idx])); m_acc = tbl[idx]; idx++;
         end
         if (out_valid && out_ready) begin
            vectors++;
            if (sbq.size() == 0) begin miscompares++; $display("FAIL chain_extra: got %h, required no output", out_result); end
            else begin
               e = sbq.pop_front();
               if ({out_result, out_zero, out_parity} !== e) begin
                  miscompares++;
                  $display("FAIL chain_result: got %h z%b p%b, required %h z%b p%b", out_result, out_zero, out_parity, e.res, e.zero, e.parity);
               end
            end
         end
         tick();
      end
      in_valid = 1'b0; in_chain = 1'b0;
      vectors++;
      if (sbq.size() != 0 || idx != 3) begin miscompares++; $display("FAIL chain_drain: got %0d pending/%0d sent, required 0/3", sbq.size(), idx); end
   endtask

   task automatic test_reset_midflight();
      exp_t e;
      int sent = 0;
      out_ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         in_valid = 1'b1; in_op = 3'd3; in_a = 8'h3C; in_b = 8'(c); in_chain = 1'b0;
         @(negedge clk);
         if (in_valid && in_ready) model_accept();
         tick();
      end
      rst = 1'b1; in_valid = 1'b0;
      tick();
      rst = 1'b0;
      sbq.delete(); m_acc = '0;
      @(negedge clk);
      vectors += 4;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_out_valid: got %b, required 0", out_valid); end
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_in_ready: got %b, required 1", in_ready); end
      if (out_result !== 8'h00) begin miscompares++; $display("FAIL rstmid_out_result: got %h, required 00", out_result); end
      if (out_zero !== 1'b1) begin miscompares++; $display("FAIL rstmid_out_zero: got %b, required 1", out_zero); end
      tick();
      out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         in_valid = (sent == 0); in_op = 3'd3; in_a = 8'h7E; in_b = 8'h81; in_chain = 1'b1;
         @(negedge clk);
         if (in_valid && in_ready) begin sbq.push_back(mk(8'h81)); m_acc = 8'h81; sent++; end
         if (out_valid && out_ready) begin
            vectors++;
            if (sbq.size() == 0) begin miscompares++; $display("FAIL rstmid_extra: got %h, required no output", out_result); end
            else begin
               e = sbq.pop_front();
               if ({out_result, out_zero, out_parity} !== e) begin
                  miscompares++;
                  $display("FAIL rstmid_chain: got %h z%b p%b, required %h z%b p%b", out_result, out_zero, out_parity, e.res, e.zero, e.parity);
               end
            end
         end
         tick();
      end
      in_valid = 1'b0; in_chain = 1'b0;
      vectors++;
      if (sbq.size() != 0 || sent != 1) begin miscompares++; $display("FAIL rstmid_drain: got %0d pending/%0d sent, required 0/1", sbq.size(), sent); end
   endtask

`ifdef LOGIC_UNIT_POPCNT_EN
   task automatic test_popcnt();
      logic [2:0]       ops [2];
      logic [WIDTH-1:0] as  [2];
      logic [WIDTH-1:0] bs  [2];
      int               pcs [2];
      int               pq[$];
      int               pexp;
      exp_t e;
      int idx = 0;
      ops = '{3'd3, 3'd2}; as = '{8'hF0, 8'h00}; bs = '{8'h01, 8'hFF}; pcs = '{5, 0};
      out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         in_valid = (idx < 2); in_chain = 1'b0;
         if (idx < 2) begin in_op = ops[idx]; in_a = as[idx]; in_b = bs[idx]; end
         @(negedge clk);
         if (in_valid && in_ready) begin model_accept(); pq.push_back(pcs[idx]); idx++; end
         if (out_valid && out_ready) begin
            vectors++;
            if (sbq.size() == 0 || pq.size() == 0) begin miscompares++; $display("FAIL pop_extra: got %h, required no output", out_result); end
            else begin
               e = sbq.pop_front(); pexp = pq.pop_front();
               if ({out_result, out_zero, out_parity} !== e || int'(out_popcnt) != pexp) begin
                  miscompares++;
                  $display("FAIL popcnt: got %h z%b cnt%0d, required %h z%b cnt%0d", out_result, out_zero, out_popcnt, e.res, e.zero, pexp);
               end
            end
         end
         tick();
      end
      in_valid = 1'b0;
      vectors++;
      if (sbq.size() != 0 || idx != 2) begin miscompares++; $display("FAIL pop_drain: got %0d pending/%0d sent, required 0/2", sbq.size(), idx); end
   endtask
`endif

   initial begin
      test_reset();
      test_all_ops();
      test_back_to_back();
      test_backpressure();
      test_random_stall();
      test_chain();
      test_reset_midflight();
`ifdef LOGIC_UNIT_POPCNT_EN
      test_popcnt();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
